// File: rtl/pe_inject_scheduler.sv
// pe_inject_scheduler: credit-based injection scheduler sharing one 20-bit
// flit link between N processing-element sources. Round-robin arbitration
// is locked per packet (head..tail), and downstream buffer credits returned
// on ci keep the router input buffer from overflowing.
module pe_inject_scheduler #(
  parameter int N       = 4,  // number of requesting sources (2..8)
  parameter int CREDITS = 4,  // downstream buffer depth (1..7)
  parameter int CW      = 3   // credit counter width, 2^CW > CREDITS
) (
  input  logic            clk,
  input  logic            RST,        // asynchronous, active low
  input  logic [N-1:0]    req_valid,
  input  logic [20*N-1:0] req_data,
  output logic [N-1:0]    req_ready,
  input  logic            ci,
  output logic [19:0]     dataout,
  output logic            out_valid,
  output logic [CW-1:0]   credits,
  output logic            proto_err
);

  localparam int          IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  typedef enum logic { ST_IDLE, ST_LOCK } state_e;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_TAIL   = 2'b01,
    FT_HEAD   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   credits_q, credits_d;
  logic [19:0]     dataout_q, dataout_d;
  logic            out_valid_q, out_valid_d;
  logic            proto_err_q, proto_err_d;

  logic            grant_found;
  logic [IW-1:0]   grant_idx;
  logic            send;
  logic [19:0]     sel_flit;
  flit_type_e      sel_type;

  // Pick the candidate source: round-robin search in IDLE, the owner in LOCK.
  // NOTE: every variable assigned in an always_comb gets a default at the top,
  // so no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    if (state_q == ST_IDLE) begin
      for (int k = 1; k <= N; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= N) idx = idx - N;
        if (!grant_found && req_valid[idx]) begin
          grant_found = 1'b1;
          grant_idx   = IW'(idx);
        end
      end
    end else begin
      grant_idx   = owner_q;
      grant_found = req_valid[owner_q];
    end
  end

  // One-hot ready to the candidate only while a downstream credit is available;
  // also select the candidate's flit for the output register.
  always_comb begin
    req_ready = '0;
    sel_flit  = '0;
    if (grant_found && (credits_q != '0)) req_ready[grant_idx] = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == IW'(i)) sel_flit = req_data[i*20 +: 20];
    end
    sel_type = flit_type_e'(sel_flit[19:18]);
    send     = |(req_valid & req_ready);
  end

  // Next-state: packet lock FSM, round-robin pointer, credits, output flit.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    credits_d   = credits_q;
    proto_err_d = proto_err_q;
    dataout_d   = dataout_q;
    out_valid_d = send;

    if (send) begin
      dataout_d = sel_flit;
      unique case (state_q)
        ST_IDLE: begin
          rr_ptr_d = grant_idx;
          unique case (sel_type)
            FT_HEAD: begin
              state_d = ST_LOCK;
              owner_d = grant_idx;
            end
            FT_SINGLE: state_d = ST_IDLE;
            default:   proto_err_d = 1'b1;  // body/tail without a head
          endcase
        end
        ST_LOCK: begin
          unique case (sel_type)
            FT_TAIL: state_d = ST_IDLE;
            FT_BODY: state_d = ST_LOCK;
            default: proto_err_d = 1'b1;    // head inside a packet: restart, keep lock
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A credit returned this cycle only becomes usable next cycle.
    if (send && !ci) begin
      credits_d = credits_q - CW'(1);
    end else if (!send && ci) begin
      if (credits_q == CRED_MAX) proto_err_d = 1'b1;
      else                       credits_d   = credits_q + CW'(1);
    end
  end

  // State registers; reset drops any lock and restores the full credit count.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      credits_q   <= CRED_MAX;
      dataout_q   <= '0;
      out_valid_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      credits_q   <= credits_d;
      dataout_q   <= dataout_d;
      out_valid_q <= out_valid_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign dataout   = dataout_q;
  assign out_valid = out_valid_q;
  assign credits   = credits_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_pe_inject_scheduler.sv
// Testbench for pe_inject_scheduler: directed stimulus with a scoreboard.
// The driver pushes each expected output flit when it issues the accepting
// cycle; an independent monitor pops and compares whenever out_valid is seen.
module tb_pe_inject_scheduler;

  localparam int N = 4;

  logic          clk;
  logic          RST;
  logic [N-1:0]  req_valid;
  logic [20*N-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          ci;
  logic [19:0]   dataout;
  logic          out_valid;
  logic [2:0]    credits;
  logic          proto_err;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];

  pe_inject_scheduler #(.N(4), .CREDITS(4), .CW(3)) dut (
    .clk       (clk),
    .RST       (RST),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .ci        (ci),
    .dataout   (dataout),
    .out_valid (out_valid),
    .credits   (credits),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_flit(input int i, input logic [19:0] f);
    req_data[i*20 +: 20] = f;
  endtask

  // Called at a falling edge: drive one cycle of inputs, check the
  // combinational ready vector, record the expected flit, wait one cycle.
  task automatic cycle(input logic [3:0] v, input logic c, input logic [3:0] exp_rdy,
                       input logic push, input logic [19:0] flit);
    req_valid = v;
    ci        = c;
    #1;
    check("req_ready", {28'b0, req_ready}, {28'b0, exp_rdy});
    if (push) exp_q.push_back(flit);
    @(negedge clk);
  endtask

  // Monitor: compare every presented flit against the scoreboard.
  always @(negedge clk) begin
    logic [19:0] exp_flit;
    if (RST && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dataout_unexpected: got 0x%0h expected no flit at %0t", dataout, $time);
      end else begin
        exp_flit = exp_q.pop_front();
        check("dataout", {12'b0, dataout}, {12'b0, exp_flit});
      end
    end
  end

  initial begin
    RST       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    ci        = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_dataout",   {12'b0, dataout},   32'd0);
    check("rst_credits",   {29'b0, credits},   32'd4);
    check("rst_proto_err", {31'b0, proto_err}, 32'd0);
    check("rst_req_ready", {28'b0, req_ready}, 32'd0);
    RST = 1'b1;

    // 1: idle, nothing happens
    repeat (3) cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 20'h0);
    check("t1_credits",   {29'b0, credits},   32'd4);
    check("t1_out_valid", {31'b0, out_valid}, 32'd0);

    // 2: single-flit packet from src0, one-cycle latency, one credit consumed
    set_flit(0, 20'hC0001);
    cycle(4'b0001, 1'b0, 4'b0001, 1'b1, 20'hC0001);
    check("t2_credits", {29'b0, credits}, 32'd3);
    cycle(4'b0000, 1'b1, 4'b0000, 1'b0, 20'h0);
    check("t2_credits_back", {29'b0, credits},   32'd4);
    check("t2_out_valid_lo", {31'b0, out_valid}, 32'd0);
    check("t2_dataout_hold", {12'b0, dataout},   32'hC0001);

    // 3: all sources hold singles; round robin 1,2,3,0,1,2 with ci after first send
    for (int i = 0; i < N; i++) set_flit(i, 20'hC00A0 + 20'(i));
    cycle(4'b1111, 1'b0, 4'b0010, 1'b1, 20'hC00A1);
    cycle(4'b1111, 1'b1, 4'b0100, 1'b1, 20'hC00A2);
    cycle(4'b1111, 1'b1, 4'b1000, 1'b1, 20'hC00A3);
    cycle(4'b1111, 1'b1, 4'b0001, 1'b1, 20'hC00A0);
    cycle(4'b1111, 1'b1, 4'b0010, 1'b1, 20'hC00A1);
    cycle(4'b1111, 1'b1, 4'b0100, 1'b1, 20'hC00A2);
    check("t3_credits", {29'b0, credits}, 32'd3);
    cycle(4'b0000, 1'b1, 4'b0000, 1'b0, 20'h0);
    check("t3_credits_back", {29'b0, credits}, 32'd4);

    // 4: src2 locked packet; src1 stalls, then granted right after the tail
    set_flit(2, 20'h82000);
    set_flit(1, 20'hC1111);
    cycle(4'b0100, 1'b0, 4'b0100, 1'b1, 20'h82000);
    set_flit(2, 20'h02001);
    cycle(4'b0110, 1'b1, 4'b0100, 1'b1, 20'h02001);
    set_flit(2, 20'h02002);
    cycle(4'b0110, 1'b1, 4'b0100, 1'b1, 20'h02002);
    set_flit(2, 20'h42003);
    cycle(4'b0110, 1'b1, 4'b0100, 1'b1, 20'h42003);
    cycle(4'b0010, 1'b1, 4'b0010, 1'b1, 20'hC1111);
    cycle(4'b0000, 1'b1, 4'b0000, 1'b0, 20'h0);
    check("t4_credits",   {29'b0, credits},   32'd4);
    check("t4_proto_err", {31'b0, proto_err}, 32'd0);

    // 5: exhaust credits, single returned credit, then over-return
    for (int k = 0; k < 4; k++) begin
      set_flit(3, 20'hC3000 + 20'(k));
      cycle(4'b1000, 1'b0, 4'b1000, 1'b1, 20'hC3000 + 20'(k));
    end
    set_flit(3, 20'hC3004);
    cycle(4'b1000, 1'b0, 4'b0000, 1'b0, 20'h0);
    check("t5_credits_zero", {29'b0, credits}, 32'd0);
    cycle(4'b1000, 1'b1, 4'b0000, 1'b0, 20'h0);   // credit not usable same cycle
    cycle(4'b1000, 1'b0, 4'b1000, 1'b1, 20'hC3004);
    cycle(4'b1000, 1'b0, 4'b0000, 1'b0, 20'h0);
    repeat (4) cycle(4'b0000, 1'b1, 4'b0000, 1'b0, 20'h0);
    check("t5_credits_full", {29'b0, credits},   32'd4);
    check("t5_no_err_yet",   {31'b0, proto_err}, 32'd0);
    cycle(4'b0000, 1'b1, 4'b0000, 1'b0, 20'h0);
    check("t5_credits_sat", {29'b0, credits},   32'd4);
    check("t5_proto_err",   {31'b0, proto_err}, 32'd1);

    // 6: reset in the middle of a packet from src0 with one credit left
    set_flit(0, 20'h80100);
    cycle(4'b0001, 1'b0, 4'b0001, 1'b1, 20'h80100);
    set_flit(0, 20'h00101);
    cycle(4'b0001, 1'b0, 4'b0001, 1'b1, 20'h00101);
    set_flit(0, 20'h00102);
    cycle(4'b0001, 1'b0, 4'b0001, 1'b1, 20'h00102);
    check("t6_credits_pre", {29'b0, credits}, 32'd1);
    req_valid = '0;
    #2 RST = 1'b0;
    #1;
    check("t6_out_valid",  {31'b0, out_valid}, 32'd0);
    check("t6_credits",    {29'b0, credits},   32'd4);
    check("t6_proto_err",  {31'b0, proto_err}, 32'd0);
    @(negedge clk);
    RST = 1'b1;
    set_flit(1, 20'h80201);
    cycle(4'b0010, 1'b0, 4'b0010, 1'b1, 20'h80201);
    set_flit(1, 20'h40202);
    set_flit(0, 20'hC0000);
    cycle(4'b0011, 1'b0, 4'b0010, 1'b1, 20'h40202);
    cycle(4'b0001, 1'b0, 4'b0001, 1'b1, 20'hC0000);
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 20'h0);
    check("t6_credits_end", {29'b0, credits}, 32'd1);

    repeat (2) cycle(4'b0000, 1'b0, 4'b0000, 1'b0, 20'h0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
